// File: rtl/wb_write_queue_pkg.sv
// Shared types and helpers for the register-bank write-back queue.
package wb_write_queue_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 8;
  localparam int WB_DATA_W  = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0]  data;
  } wb_entry_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/wb_write_queue_bypass.sv
// Youngest-first address match over the pending queue entries.
module wb_bypass_match
  import wb_write_queue_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic [REG_ADDR_W-1:0] addr_i [DEPTH],
  input  logic [DATA_W-1:0]     data_i [DEPTH],
  input  logic [DEPTH-1:0]      valid_i,
  input  logic [ptr_w(DEPTH)-1:0] tail_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  output logic                  hit_o,
  output logic [DATA_W-1:0]     data_o
);

  localparam int PW = ptr_w(DEPTH);

  logic [PW-1:0] idx;

  // Scan oldest to youngest so the youngest match is the last to win.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail_i - PW'(k);
      if (valid_i[idx] && addr_i[idx] == rd_addr_i) begin
        hit_o  = 1'b1;
        data_o = data_i[idx];
      end
    end
  end

endmodule

// File: rtl/wb_write_queue.sv
// Write-back queue feeding the register bank write decoder.
// Define WB_DROP_R0_EN to accept but discard writes to register 0.
module wb_write_queue
  import wb_write_queue_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  bank_busy,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic                  wr_en,
  output logic [DATA_W-1:0]     wr_data,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  output logic                  rd_hit,
  output logic [DATA_W-1:0]     rd_data
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [REG_ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0]     data_q [DEPTH];
  logic [PW-1:0]         off [DEPTH];
  logic [DEPTH-1:0]      valid;
  logic                  push, pop, enq;

  assign in_ready = (count_q != CW'(DEPTH));
  assign wr_en    = (count_q != '0) && !bank_busy;
  assign pop      = wr_en;
  assign push     = in_valid && in_ready;

`ifdef WB_DROP_R0_EN
  assign enq = push && (in_addr != '0);
`else
  assign enq = push;
`endif

  assign wr_addr = addr_q[head_q];
  assign wr_data = data_q[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) head_d = head_q + PW'(1);
    if (enq) tail_d = tail_q + PW'(1);
    unique case ({enq, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is intentionally not reset; validity comes from count.
  always_ff @(posedge clock) begin
    if (enq) begin
      addr_q[tail_q] <= in_addr;
      data_q[tail_q] <= in_data;
    end
  end

  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off[i]   = PW'(i) - head_q;
      valid[i] = ({1'b0, off[i]} < count_q);
    end
  end

  wb_bypass_match #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_bypass (
    .addr_i    (addr_q),
    .data_i    (data_q),
    .valid_i   (valid),
    .tail_i    (tail_q),
    .rd_addr_i (rd_addr),
    .hit_o     (rd_hit),
    .data_o    (rd_data)
  );

endmodule

// File: tb/tb_wb_write_queue.sv
// Scoreboard bench for the write-back queue.
// Honours WB_DROP_R0_EN when the design is built with it.
module tb_wb_write_queue;
  import wb_write_queue_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_addr = '0;
  logic [31:0] in_data = '0;
  logic        bank_busy = 1'b0;
  logic [2:0]  wr_addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [2:0]  rd_addr = '0;
  logic        rd_hit;
  logic [31:0] rd_data;

  int vectors = 0;
  int miscompares = 0;

  wb_entry_t sb[$];
  wb_entry_t exp_e;
  logic      keep;

  wb_write_queue #(
    .DATA_W (32),
    .DEPTH  (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .bank_busy (bank_busy),
    .wr_addr   (wr_addr),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_hit    (rd_hit),
    .rd_data   (rd_data)
  );

  always #5 clock = ~clock;

  // Commit monitor: mid-cycle, compare commits and record accepted pushes.
  always @(negedge clock) begin
    if (!reset) begin
      if (wr_en) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL commit_unexpected: got addr=%0d data=%h, queue model empty",
                   wr_addr, wr_data);
        end else begin
          exp_e = sb.pop_front();
          if (wr_addr !== exp_e.addr || wr_data !== exp_e.data) begin
            miscompares++;
            $display("FAIL commit_order: got addr=%0d data=%h, want addr=%0d data=%h",
                     wr_addr, wr_data, exp_e.addr, exp_e.data);
          end
        end
      end
      if (in_valid && in_ready) begin
        keep = 1'b1;
`ifdef WB_DROP_R0_EN
        keep = (in_addr != 3'd0);
`endif
        if (keep) sb.push_back('{addr: in_addr, data: in_data});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 12 && sb.size() != 0; i++) tick();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: %0d entries left, want 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock);
    vectors++;
    if (in_ready !== 1'b1 || wr_en !== 1'b0 ||
        rd_hit !== 1'b0 || rd_data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: rdy=%b en=%b hit=%b rdata=%h, want 1 0 0 0",
               in_ready, wr_en, rd_hit, rd_data);
    end
    tick();
    reset = 1'b0;
    @(negedge clock);
    vectors++;
    if (in_ready !== 1'b1 || wr_en !== 1'b0 || rd_hit !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_outputs: rdy=%b en=%b hit=%b, want 1 0 0",
               in_ready, wr_en, rd_hit);
    end
    tick();
  endtask

  task automatic test_single();
    bank_busy = 1'b0;
    in_valid  = 1'b1;
    in_addr   = 3'd5;
    in_data   = 32'hDEADBEEF;
    @(negedge clock);
    vectors++;
    if (wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL single_no_fallthrough: wr_en=%b, want 0", wr_en);
    end
    tick();
    in_valid = 1'b0;
    @(negedge clock);
    vectors++;
    if (wr_en !== 1'b1 || wr_addr !== 3'd5 || wr_data !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL single_commit: en=%b addr=%0d data=%h, want 1 5 deadbeef",
               wr_en, wr_addr, wr_data);
    end
    tick();
    @(negedge clock);
    vectors++;
    if (wr_en !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL single_empty: en=%b rdy=%b, want 0 1", wr_en, in_ready);
    end
    tick();
  endtask

  task automatic test_full();
    bank_busy = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_addr = 3'(i + 1);
      in_data = $urandom;
      tick();
    end
    in_addr   = 3'd7;
    in_data   = 32'hBAD0BAD0;
    @(negedge clock);
    vectors++;
    if (in_ready !== 1'b0 || wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL full_busy: rdy=%b en=%b, want 0 0", in_ready, wr_en);
    end
    tick();
    bank_busy = 1'b0;
    @(negedge clock);
    vectors++;
    if (in_ready !== 1'b0 || wr_en !== 1'b1) begin
      miscompares++;
      $display("FAIL full_pop_refuse: rdy=%b en=%b, want 0 1", in_ready, wr_en);
    end
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      vectors++;
      if (wr_en !== 1'b1) begin
        miscompares++;
        $display("FAIL full_drain_%0d: wr_en=%b, want 1", i, wr_en);
      end
      tick();
    end
    @(negedge clock);
    vectors++;
    if (wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL full_after_drain: wr_en=%b, want 0", wr_en);
    end
    tick();
    drain("full");
  endtask

  task automatic test_bypass();
    bank_busy = 1'b1;
    in_valid  = 1'b1;
    in_addr   = 3'd3;
    in_data   = 32'h11;
    tick();
    in_data   = 32'h22;
    tick();
    in_valid  = 1'b0;
    rd_addr   = 3'd3;
    @(negedge clock);
    vectors++;
    if (rd_hit !== 1'b1 || rd_data !== 32'h22) begin
      miscompares++;
      $display("FAIL bypass_youngest: hit=%b data=%h, want 1 22", rd_hit, rd_data);
    end
    rd_addr = 3'd4;
    #1;
    vectors++;
    if (rd_hit !== 1'b0 || rd_data !== 32'd0) begin
      miscompares++;
      $display("FAIL bypass_miss: hit=%b data=%h, want 0 0", rd_hit, rd_data);
    end
    rd_addr = 3'd3;
    tick();
    bank_busy = 1'b0;
    tick();
    bank_busy = 1'b1;
    @(negedge clock);
    vectors++;
    if (rd_hit !== 1'b1 || rd_data !== 32'h22) begin
      miscompares++;
      $display("FAIL bypass_after_pop1: hit=%b data=%h, want 1 22", rd_hit, rd_data);
    end
    tick();
    bank_busy = 1'b0;
    tick();
    bank_busy = 1'b1;
    @(negedge clock);
    vectors++;
    if (rd_hit !== 1'b0 || rd_data !== 32'd0) begin
      miscompares++;
      $display("FAIL bypass_after_pop2: hit=%b data=%h, want 0 0", rd_hit, rd_data);
    end
    tick();
    bank_busy = 1'b0;
    drain("bypass");
  endtask

  task automatic test_back_to_back();
    bank_busy = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_addr = 3'($urandom_range(1, 7));
      in_data = $urandom;
      tick();
    end
    bank_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_addr = 3'($urandom_range(1, 7));
      in_data = $urandom;
      @(negedge clock);
      vectors++;
      if (in_ready !== 1'b1 || wr_en !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_cycle_%0d: rdy=%b en=%b, want 1 1", i, in_ready, wr_en);
      end
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      vectors++;
      if (wr_en !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_tail_%0d: wr_en=%b, want 1", i, wr_en);
      end
      tick();
    end
    @(negedge clock);
    vectors++;
    if (wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_count: wr_en=%b after 2 drains, want 0", wr_en);
    end
    tick();
    drain("b2b");
  endtask

  task automatic test_r0();
    logic exp_en;
`ifdef WB_DROP_R0_EN
    exp_en = 1'b0;
`else
    exp_en = 1'b1;
`endif
    bank_busy = 1'b0;
    in_valid  = 1'b1;
    in_addr   = 3'd0;
    in_data   = 32'h55;
    rd_addr   = 3'd0;
    @(negedge clock);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL r0_handshake: rdy=%b, want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    @(negedge clock);
    vectors++;
    if (wr_en !== exp_en || rd_hit !== exp_en) begin
      miscompares++;
      $display("FAIL r0_commit: en=%b hit=%b, want %b %b",
               wr_en, rd_hit, exp_en, exp_en);
    end
    if (exp_en) begin
      vectors++;
      if (wr_addr !== 3'd0 || rd_data !== 32'h55) begin
        miscompares++;
        $display("FAIL r0_addr: addr=%0d rdata=%h, want 0 55", wr_addr, rd_data);
      end
    end
    tick();
    drain("r0");
  endtask

  task automatic test_reset_mid();
    bank_busy = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_addr = 3'(i + 2);
      in_data = $urandom;
      tick();
    end
    in_valid = 1'b0;
    rd_addr  = 3'd2;
    reset    = 1'b1;
    sb.delete();
    @(negedge clock);
    vectors++;
    if (wr_en !== 1'b0 || in_ready !== 1'b1 || rd_hit !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_during: en=%b rdy=%b hit=%b, want 0 1 0",
               wr_en, in_ready, rd_hit);
    end
    tick();
    reset     = 1'b0;
    bank_busy = 1'b0;
    @(negedge clock);
    vectors++;
    if (wr_en !== 1'b0 || in_ready !== 1'b1 || rd_hit !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_after: en=%b rdy=%b hit=%b, want 0 1 0",
               wr_en, in_ready, rd_hit);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_bypass();
    test_back_to_back();
    test_r0();
    test_reset_mid();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL final_empty: %0d expected commits left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Write-back queue for the 8-entry register bank, one stage upstream of the bank's 3-to-8 write-enable decoder.
- Buffers register write requests (3-bit address plus data) from the execute/write-back stage.
- Drains them one per cycle as an address/enable pair into the decoder; stalls while the bank is busy.
- Provides a read-bypass port so pending writes are visible to operand reads before they commit.

Parameters:
- DATA_W, 32, width of the write data word.
- DEPTH, 4, number of queue entries; must be a power of 2, at least 2.

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in_valid  input  1  write request present.
- in_ready  output  1  queue can accept a request this cycle.
- in_addr  input  3  destination register index.
- in_data  input  DATA_W  write data.
- bank_busy  input  1  bank cannot commit a write this cycle.
- wr_addr  output  3  head entry address; drives decoder data[2:0].
- wr_en  output  1  commit strobe; drives decoder en.
- wr_data  output  DATA_W  head entry data.
- rd_addr  input  3  bypass lookup address.
- rd_hit  output  1  a pending entry targets rd_addr.
- rd_data  output  DATA_W  data of the youngest matching pending entry.

Behaviour:
- Storage: circular buffer of DEPTH entries {addr, data}. Head and tail pointers are log2(DEPTH) bits and wrap naturally. A count register of log2(DEPTH)+1 bits tracks occupancy.
- Push: in_valid && in_ready at a clock edge. The entry is written at the tail, tail increments, count increments.
- Pop: wr_en at a clock edge. Head increments, count decrements.
- in_ready = (count != DEPTH). It is registered-state only, with no combinational path from bank_busy or the pop. When full, a push is refused even if a pop occurs in the same cycle.
- wr_en = (count != 0) && !bank_busy. It is combinational from state and bank_busy.
- wr_addr and wr_data always show the head entry. When empty they hold stale values, and wr_en = 0.
- Latency: a request pushed at edge N can appear on wr_en in cycle N+1 at the earliest. There is no same-cycle fall-through.
- Simultaneous push and pop when 0 < count < DEPTH: count is unchanged and both pointers advance.
- Simultaneous push and pop when count == 0: impossible, because wr_en = 0.
- Order: entries are committed strictly FIFO. Multiple pending writes to the same address are all committed in order.
- Bypass: rd_hit is combinational over valid entries only. rd_data comes from the youngest valid entry with addr == rd_addr (priority tail-1 down to head). When there is no hit, rd_hit = 0 and rd_data = 0.
- The bypass does not see the in_data of a request being pushed in the same cycle.
- Reset, including mid-operation: head = tail = count = 0 and all pending writes are discarded. Outputs during and after reset: in_ready = 1, wr_en = 0, rd_hit = 0, rd_data = 0. Storage contents are not cleared.

Optional Feature:
- Macro: WB_DROP_R0_EN.
- Defined: a request with in_addr == 0 is accepted (handshake completes normally) but not enqueued. Count, tail and bypass are unaffected. A register-0 write never reaches the decoder.
- Undefined: address 0 is queued and committed like any other address.

Decomposition:
- Shared package holds:
  - REG_ADDR_W = 3 and NUM_REGS = 8.
  - A typedef wb_entry_t {addr[REG_ADDR_W-1:0], data[DATA_W-1:0]}.
  - A function for the pointer width, log2(DEPTH).
- One natural sub-module: wb_bypass_match. It is a combinational youngest-first match over the entry array plus a valid mask, and it outputs hit and data.
- The FIFO control stays in the top.

Test Plan:
- Reset then idle: in_ready = 1, wr_en = 0, rd_hit = 0. Assert reset mid-stream with 3 entries pending; next cycle wr_en = 0 and in_ready = 1.
- Push addr 5 / data 0xDEADBEEF at edge N with bank_busy = 0: wr_en = 1, wr_addr = 5, wr_data = 0xDEADBEEF in cycle N+1; queue empty after edge N+1.
- Hold bank_busy = 1 and push 4 entries: in_ready = 0 after the 4th, and a 5th push is refused. Release busy: 4 commits in push order, one per cycle.
- Push addr 3 / 0x11 then addr 3 / 0x22, busy held, rd_addr = 3: rd_hit = 1, rd_data = 0x22. After the first pop still 0x22; after the second pop rd_hit = 0.
- Steady state with 2 entries: push and pop every cycle for 20 cycles with pointers wrapping; count stays 2 and data order is preserved.
- With WB_DROP_R0_EN defined, push addr 0 / 0x55: in_ready handshake completes, wr_en never rises, rd_addr = 0 gives rd_hit = 0. Without the macro, it commits with wr_addr = 0.
